// File: rtl/cnn_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | cnn_pkg : state encoding and output-geometry helpers for the CNN stages   |
// | Rev 1.0 : initial release                                                 |
// +----------------------------------------------------------------------------+
package cnn_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPUTE = 2'd1,
        EMIT    = 2'd2,
        FINISH  = 2'd3
    } conv_state_t;

    // Number of valid window positions along one axis (floor division).
    function automatic int calc_out_dim(input int image_dim, input int kernel_size,
                                        input int stride);
        return (image_dim - kernel_size) / stride + 1;
    endfunction

    // Wide enough that K*K full-precision products never overflow.
    function automatic int calc_acc_width(input int pixel_width, input int weight_width,
                                          input int kernel_size);
        return pixel_width + weight_width + $clog2(kernel_size * kernel_size);
    endfunction

endpackage
`default_nettype wire

// File: rtl/window_mac.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | window_mac : combinational signed K*K window/kernel dot product           |
// | Rev 1.0 : initial release                                                 |
// +----------------------------------------------------------------------------+
module window_mac
    import cnn_pkg::*;
#(
    parameter int KERNEL_SIZE  = 3,
    parameter int PIXEL_WIDTH  = 2,
    parameter int WEIGHT_WIDTH = 2,
    parameter int ACC_WIDTH    = calc_acc_width(PIXEL_WIDTH, WEIGHT_WIDTH, KERNEL_SIZE)
) (
    input  logic        [PIXEL_WIDTH*KERNEL_SIZE*KERNEL_SIZE-1:0]  window,
    input  logic        [WEIGHT_WIDTH*KERNEL_SIZE*KERNEL_SIZE-1:0] kernel,
    output logic signed [ACC_WIDTH-1:0]                            sum
);

    localparam int c_KK         = KERNEL_SIZE * KERNEL_SIZE;
    localparam int c_PROD_WIDTH = PIXEL_WIDTH + WEIGHT_WIDTH;

    logic signed [c_PROD_WIDTH-1:0] w_px;
    logic signed [c_PROD_WIDTH-1:0] w_wt;
    logic signed [c_PROD_WIDTH-1:0] w_prod;

    // Element 0 sits in the MSBs of both packed vectors.
    always_comb begin
        w_px   = '0;
        w_wt   = '0;
        w_prod = '0;
        sum    = '0;
        for (int i = 0; i < c_KK; i++) begin
            w_px   = c_PROD_WIDTH'($signed(window[(c_KK-1-i)*PIXEL_WIDTH +: PIXEL_WIDTH]));
            w_wt   = c_PROD_WIDTH'($signed(kernel[(c_KK-1-i)*WEIGHT_WIDTH +: WEIGHT_WIDTH]));
            w_prod = w_px * w_wt;
            sum    = sum + ACC_WIDTH'(w_prod);
        end
    end

endmodule
`default_nettype wire

// File: rtl/conv_stream_engine.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | conv_stream_engine : multi-feature 2D convolution with streamed results   |
// | Optional macro CONV_RELU_EN clamps negative sums to zero.                 |
// | Rev 1.0 : initial release                                                 |
// +----------------------------------------------------------------------------+
module conv_stream_engine
    import cnn_pkg::*;
#(
    parameter int IMAGE_WIDTH  = 12,
    parameter int IMAGE_HEIGHT = 12,
    parameter int NUM_FEATURES = 2,
    parameter int KERNEL_SIZE  = 3,
    parameter int STRIDE       = 1,
    parameter int PIXEL_WIDTH  = 2,
    parameter int WEIGHT_WIDTH = 2
) (
    input  logic                                                       clk,
    input  logic                                                       rst,
    input  logic [PIXEL_WIDTH*IMAGE_HEIGHT*IMAGE_WIDTH-1:0]            image_input,
    input  logic [WEIGHT_WIDTH*KERNEL_SIZE*KERNEL_SIZE-1:0]            weights_input,
    input  logic [$clog2(NUM_FEATURES):0]                              feature_writeAddr,
    input  logic                                                       feature_WrEn,
    input  logic                                                       start,
    output logic                                                       busy,
    output logic                                                       done,
    output logic signed [calc_acc_width(PIXEL_WIDTH, WEIGHT_WIDTH, KERNEL_SIZE)-1:0] out_data,
    output logic [$clog2(NUM_FEATURES):0]                              out_feature,
    output logic [$clog2(calc_out_dim(IMAGE_HEIGHT, KERNEL_SIZE, STRIDE)):0] out_row,
    output logic [$clog2(calc_out_dim(IMAGE_WIDTH, KERNEL_SIZE, STRIDE)):0]  out_col,
    output logic                                                       out_valid,
    input  logic                                                       out_ready
);

    localparam int c_OUT_W     = calc_out_dim(IMAGE_WIDTH, KERNEL_SIZE, STRIDE);
    localparam int c_OUT_H     = calc_out_dim(IMAGE_HEIGHT, KERNEL_SIZE, STRIDE);
    localparam int c_ACC_WIDTH = calc_acc_width(PIXEL_WIDTH, WEIGHT_WIDTH, KERNEL_SIZE);
    localparam int c_FW        = $clog2(NUM_FEATURES) + 1;
    localparam int c_RW        = $clog2(c_OUT_H) + 1;
    localparam int c_CW        = $clog2(c_OUT_W) + 1;
    localparam int c_KK        = KERNEL_SIZE * KERNEL_SIZE;
    localparam int c_NPIX      = IMAGE_HEIGHT * IMAGE_WIDTH;
    localparam int c_IMG_BITS  = PIXEL_WIDTH * c_NPIX;
    localparam int c_KER_BITS  = WEIGHT_WIDTH * c_KK;
    localparam int c_WIN_BITS  = PIXEL_WIDTH * c_KK;
    // Depth covers the whole address range so the slot index never needs trimming.
    localparam int c_MEM_DEPTH = 2 ** c_FW;

    localparam logic [c_FW-1:0] c_LAST_FEAT = c_FW'(NUM_FEATURES - 1);
    localparam logic [c_RW-1:0] c_LAST_ROW  = c_RW'(c_OUT_H - 1);
    localparam logic [c_CW-1:0] c_LAST_COL  = c_CW'(c_OUT_W - 1);

    conv_state_t                    r_state;
    conv_state_t                    w_next_state;
    logic [c_IMG_BITS-1:0]          r_image;
    logic [c_KER_BITS-1:0]          r_feat_mem [c_MEM_DEPTH];
    logic [c_FW-1:0]                r_feat;
    logic [c_RW-1:0]                r_row;
    logic [c_CW-1:0]                r_col;
    logic signed [c_ACC_WIDTH-1:0]  r_out_data;
    logic [c_FW-1:0]                r_out_feature;
    logic [c_RW-1:0]                r_out_row;
    logic [c_CW-1:0]                r_out_col;

    logic [c_WIN_BITS-1:0]          w_window;
    logic [c_KER_BITS-1:0]          w_kernel;
    logic signed [c_ACC_WIDTH-1:0]  w_sum;
    logic signed [c_ACC_WIDTH-1:0]  w_result;
    logic                           w_start_pass;
    logic                           w_accept;
    logic                           w_last_beat;
    logic                           w_wr_ok;

    assign w_last_beat = (r_feat == c_LAST_FEAT) && (r_row == c_LAST_ROW) &&
                         (r_col == c_LAST_COL);
    assign w_wr_ok     = feature_WrEn && (r_state == IDLE) &&
                         (int'(feature_writeAddr) < NUM_FEATURES);
    assign w_kernel    = r_feat_mem[r_feat];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_start_pass = 1'b0;
        w_accept     = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        out_valid    = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_start_pass = 1'b1;
                    w_next_state = COMPUTE;
                end
            end
            COMPUTE: begin
                busy         = 1'b1;
                w_next_state = EMIT;
            end
            EMIT: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    w_accept     = 1'b1;
                    w_next_state = w_last_beat ? FINISH : COMPUTE;
                end
            end
            FINISH: begin
                done         = 1'b1;
                w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Gather the K*K window at (row*STRIDE, col*STRIDE); pixel 0 of the image is in the MSBs.
    always_comb begin
        int pix_idx;
        int win_idx;
        pix_idx  = 0;
        win_idx  = 0;
        w_window = '0;
        for (int ky = 0; ky < KERNEL_SIZE; ky++) begin
            for (int kx = 0; kx < KERNEL_SIZE; kx++) begin
                win_idx = ky * KERNEL_SIZE + kx;
                pix_idx = (int'(r_row) * STRIDE + ky) * IMAGE_WIDTH +
                          int'(r_col) * STRIDE + kx;
                w_window[(c_KK-1-win_idx)*PIXEL_WIDTH +: PIXEL_WIDTH] =
                    r_image[(c_NPIX-1-pix_idx)*PIXEL_WIDTH +: PIXEL_WIDTH];
            end
        end
    end

    window_mac #(
        .KERNEL_SIZE  (KERNEL_SIZE),
        .PIXEL_WIDTH  (PIXEL_WIDTH),
        .WEIGHT_WIDTH (WEIGHT_WIDTH),
        .ACC_WIDTH    (c_ACC_WIDTH)
    ) u_window_mac (
        .window (w_window),
        .kernel (w_kernel),
        .sum    (w_sum)
    );

`ifdef CONV_RELU_EN
    assign w_result = w_sum[c_ACC_WIDTH-1] ? '0 : w_sum;
`else
    assign w_result = w_sum;
`endif

    // The image is only read between a start and the end of its pass.
    always_ff @(posedge clk) begin
        if (w_start_pass && !rst) begin
            r_image <= image_input;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_feat        <= '0;
            r_row         <= '0;
            r_col         <= '0;
            r_out_data    <= '0;
            r_out_feature <= '0;
            r_out_row     <= '0;
            r_out_col     <= '0;
            for (int i = 0; i < c_MEM_DEPTH; i++) begin
                r_feat_mem[i] <= '0;
            end
        end else begin
            if (w_wr_ok) begin
                r_feat_mem[feature_writeAddr] <= weights_input;
            end
            if (w_start_pass) begin
                r_feat <= '0;
                r_row  <= '0;
                r_col  <= '0;
            end
            if (r_state == COMPUTE) begin
                r_out_data    <= w_result;
                r_out_feature <= r_feat;
                r_out_row     <= r_row;
                r_out_col     <= r_col;
            end
            // Column fastest, then row, then feature.
            if (w_accept) begin
                if (r_col == c_LAST_COL) begin
                    r_col <= '0;
                    if (r_row == c_LAST_ROW) begin
                        r_row  <= '0;
                        r_feat <= r_feat + 1'b1;
                    end else begin
                        r_row <= r_row + 1'b1;
                    end
                end else begin
                    r_col <= r_col + 1'b1;
                end
            end
        end
    end

    assign out_data    = r_out_data;
    assign out_feature = r_out_feature;
    assign out_row     = r_out_row;
    assign out_col     = r_out_col;

endmodule
`default_nettype wire

// File: tb/tb_conv_stream_engine.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_conv_stream_engine : scoreboard bench, stride-1 and stride-2 instances |
// | Rev 1.0 : initial release                                                 |
// +----------------------------------------------------------------------------+
module tb_conv_stream_engine;

    localparam int W   = 12;
    localparam int H   = 12;
    localparam int NF  = 2;
    localparam int K   = 3;
    localparam int KK  = 9;
    localparam int PW  = 2;
    localparam int WW  = 2;
    localparam int ACC = 8;
    localparam int FW  = 2;
    localparam int OW1 = 10;
    localparam int OH1 = 10;
    localparam int OW2 = 5;
    localparam int OH2 = 5;
    localparam int RW1 = $clog2(OH1) + 1;
    localparam int CW1 = $clog2(OW1) + 1;
    localparam int RW2 = $clog2(OH2) + 1;
    localparam int CW2 = $clog2(OW2) + 1;
    localparam int TIMEOUT = 2000;

    logic                   clk;
    logic                   rst;
    logic [PW*H*W-1:0]      image_input;
    logic [WW*KK-1:0]       weights_input;
    logic [FW-1:0]          feature_writeAddr;
    logic                   feature_WrEn;
    logic                   start1, start2;
    logic                   out_ready1, out_ready2;
    logic                   busy1, busy2, done1, done2, out_valid1, out_valid2;
    logic [ACC-1:0]         out_data1, out_data2;
    logic [FW-1:0]          out_feature1, out_feature2;
    logic [RW1-1:0]         out_row1;
    logic [CW1-1:0]         out_col1;
    logic [RW2-1:0]         out_row2;
    logic [CW2-1:0]         out_col2;

    conv_stream_engine #(.STRIDE(1)) dut1 (
        .clk(clk), .rst(rst), .image_input(image_input), .weights_input(weights_input),
        .feature_writeAddr(feature_writeAddr), .feature_WrEn(feature_WrEn), .start(start1),
        .busy(busy1), .done(done1), .out_data(out_data1), .out_feature(out_feature1),
        .out_row(out_row1), .out_col(out_col1), .out_valid(out_valid1), .out_ready(out_ready1)
    );

    conv_stream_engine #(.STRIDE(2)) dut2 (
        .clk(clk), .rst(rst), .image_input(image_input), .weights_input(weights_input),
        .feature_writeAddr(feature_writeAddr), .feature_WrEn(feature_WrEn), .start(start2),
        .busy(busy2), .done(done2), .out_data(out_data2), .out_feature(out_feature2),
        .out_row(out_row2), .out_col(out_col2), .out_valid(out_valid2), .out_ready(out_ready2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int data;
        int feat;
        int row;
        int col;
    } beat_t;

    beat_t q1[$];
    beat_t q2[$];
    beat_t e1, e2;
    int    img_s [H][W];
    int    img_m [H][W];
    int    ker_m [NF][KK];
    int    checks = 0;
    int    failures = 0;
    int    cyc = 0;
    int    beats1 = 0, beats2 = 0, dones1 = 0, dones2 = 0;
    int    last_acc1 = 0, last_acc2 = 0;
    int    l_feat2 = 0, l_row2 = 0, l_col2 = 0;
    int    stall_cnt1 = 0;
    bit    stall_prev1 = 1'b0;
    int    h_data, h_feat, h_row, h_col;
    int    pass_b0, pass_d0;

    int k_x   [KK] = '{1, -1, 1, -1, 1, -1, 1, -1, 1};
    int k_one [KK] = '{1, 1, 1, 1, 1, 1, 1, 1, 1};
    int k_neg [KK] = '{-1, -1, -1, -1, -1, -1, -1, -1, -1};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Reference convolution over the image latched at the most recent start.
    function automatic int model(input int f, input int r, input int c, input int s);
        int acc;
        acc = 0;
        for (int ky = 0; ky < K; ky++)
            for (int kx = 0; kx < K; kx++)
                acc += img_m[r*s+ky][c*s+kx] * ker_m[f][ky*K+kx];
`ifdef CONV_RELU_EN
        if (acc < 0) acc = 0;
`endif
        return acc;
    endfunction

    always @(negedge clk) begin
        if (!rst && out_valid1 && out_ready1) begin
            if (q1.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL dut1_extra_beat row=%0d col=%0d", out_row1, out_col1);
            end else begin
                e1 = q1.pop_front();
                check("dut1_data", int'($signed(out_data1)), e1.data);
                check("dut1_feature", int'(out_feature1), e1.feat);
                check("dut1_row", int'(out_row1), e1.row);
                check("dut1_col", int'(out_col1), e1.col);
            end
            beats1++;
            last_acc1 = cyc;
        end
        if (!rst && done1) begin
            dones1++;
            check("dut1_done_latency", cyc - last_acc1, 1);
        end
        if (!rst && stall_prev1) begin
            check("dut1_valid_held", int'(out_valid1), 1);
            check("dut1_data_held", int'($signed(out_data1)), h_data);
            check("dut1_feature_held", int'(out_feature1), h_feat);
            check("dut1_row_held", int'(out_row1), h_row);
            check("dut1_col_held", int'(out_col1), h_col);
        end
        stall_prev1 = !rst && out_valid1 && !out_ready1;
        if (stall_prev1) begin
            stall_cnt1++;
            h_data = int'($signed(out_data1));
            h_feat = int'(out_feature1);
            h_row  = int'(out_row1);
            h_col  = int'(out_col1);
        end
    end

    always @(negedge clk) begin
        if (!rst && out_valid2 && out_ready2) begin
            if (q2.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL dut2_extra_beat row=%0d col=%0d", out_row2, out_col2);
            end else begin
                e2 = q2.pop_front();
                check("dut2_data", int'($signed(out_data2)), e2.data);
                check("dut2_feature", int'(out_feature2), e2.feat);
                check("dut2_row", int'(out_row2), e2.row);
                check("dut2_col", int'(out_col2), e2.col);
            end
            beats2++;
            last_acc2 = cyc;
            l_feat2 = int'(out_feature2);
            l_row2  = int'(out_row2);
            l_col2  = int'(out_col2);
        end
        if (!rst && done2) begin
            dones2++;
            check("dut2_done_latency", cyc - last_acc2, 1);
        end
    end

    // mode 0: all +1, 1: all -1, 2: varied pattern in [-2,1], 3: all zero
    task automatic set_image(input int mode);
        int v;
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                case (mode)
                    0: v = 1;
                    1: v = -1;
                    2: v = ((r * 3 + c) % 4) - 2;
                    default: v = 0;
                endcase
                img_s[r][c] = v;
                image_input[(H*W-1-(r*W+c))*PW +: PW] = PW'(v);
            end
        end
    endtask

    task automatic write_kernel(input int addr, input int k[KK], input bit track);
        for (int i = 0; i < KK; i++) begin
            weights_input[(KK-1-i)*WW +: WW] = WW'(k[i]);
            if (track && addr < NF) ker_m[addr][i] = k[i];
        end
        feature_writeAddr = FW'(addr);
        feature_WrEn = 1'b1;
        @(posedge clk); #1;
        feature_WrEn = 1'b0;
    endtask

    task automatic start_pass(input int which);
        img_m = img_s;
        if (which == 1) begin
            for (int f = 0; f < NF; f++)
                for (int r = 0; r < OH1; r++)
                    for (int c = 0; c < OW1; c++)
                        q1.push_back('{model(f, r, c, 1), f, r, c});
            pass_b0 = beats1;
            pass_d0 = dones1;
            start1 = 1'b1;
            @(posedge clk); #1;
            start1 = 1'b0;
        end else begin
            for (int f = 0; f < NF; f++)
                for (int r = 0; r < OH2; r++)
                    for (int c = 0; c < OW2; c++)
                        q2.push_back('{model(f, r, c, 2), f, r, c});
            pass_b0 = beats2;
            pass_d0 = dones2;
            start2 = 1'b1;
            @(posedge clk); #1;
            start2 = 1'b0;
        end
    endtask

    task automatic finish_pass(input string name, input int which, input int exp_beats);
        int n;
        n = 0;
        while (((which == 1) ? dones1 : dones2) == pass_d0 && n < TIMEOUT) begin
            @(posedge clk); #1;
            n++;
        end
        check({name, "_done_seen"}, int'(n < TIMEOUT), 1);
        repeat (4) @(posedge clk);
        #1;
        if (which == 1) begin
            check({name, "_beats"}, beats1 - pass_b0, exp_beats);
            check({name, "_done_count"}, dones1 - pass_d0, 1);
            check({name, "_busy_after"}, int'(busy1), 0);
            check({name, "_queue_left"}, q1.size(), 0);
        end else begin
            check({name, "_beats"}, beats2 - pass_b0, exp_beats);
            check({name, "_done_count"}, dones2 - pass_d0, 1);
            check({name, "_busy_after"}, int'(busy2), 0);
            check({name, "_queue_left"}, q2.size(), 0);
        end
    endtask

    task automatic wait_beats1(input string name, input int target);
        int n;
        n = 0;
        while (beats1 < target && n < TIMEOUT) begin
            @(posedge clk); #1;
            n++;
        end
        check({name, "_reached"}, int'(n < TIMEOUT), 1);
    endtask

    initial begin
        int d_before;
        rst = 1'b1;
        image_input = '0;
        weights_input = '0;
        feature_writeAddr = '0;
        feature_WrEn = 1'b0;
        start1 = 1'b0;
        start2 = 1'b0;
        out_ready1 = 1'b1;
        out_ready2 = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset_busy", int'(busy1), 0);
        check("reset_done", int'(done1), 0);
        check("reset_valid", int'(out_valid1), 0);
        check("reset_data", int'(out_data1), 0);
        check("reset_feature", int'(out_feature1), 0);
        check("reset_row", int'(out_row1), 0);
        check("reset_col", int'(out_col1), 0);

        write_kernel(0, k_x, 1'b1);
        write_kernel(1, k_one, 1'b1);

        // All-ones image: feature 0 gives 1, feature 1 gives 9.
        set_image(0);
        start_pass(1);
        finish_pass("ones", 1, 200);

        // All -1 image: feature 1 gives -9 (0 with ReLU).
        set_image(1);
        start_pass(1);
        finish_pass("minus", 1, 200);

        // Varied image, input changed after start, backpressure on beat 3.
        set_image(2);
        start_pass(1);
        set_image(3);
        stall_cnt1 = 0;
        wait_beats1("bp_wait", pass_b0 + 3);
        out_ready1 = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        out_ready1 = 1'b1;
        check("bp_stall_cycles", stall_cnt1, 4);
        finish_pass("pattern_bp", 1, 200);

        // Stride 2 on the varied image: 2*5*5 beats, last tagged (1,4,4).
        set_image(2);
        start_pass(2);
        finish_pass("stride2", 2, 50);
        check("stride2_last_feature", l_feat2, 1);
        check("stride2_last_row", l_row2, 4);
        check("stride2_last_col", l_col2, 4);

        // Reset mid-pass after 40 beats.
        set_image(0);
        start_pass(1);
        wait_beats1("rst_wait", pass_b0 + 40);
        d_before = dones1;
        rst = 1'b1;
        @(posedge clk); #1;
        check("midrst_busy", int'(busy1), 0);
        check("midrst_valid", int'(out_valid1), 0);
        rst = 1'b0;
        q1.delete();
        repeat (5) @(posedge clk);
        #1;
        check("midrst_no_done", dones1 - d_before, 0);
        write_kernel(0, k_x, 1'b1);
        write_kernel(1, k_one, 1'b1);
        set_image(2);
        start_pass(1);
        finish_pass("after_rst", 1, 200);

        // Weight write and start while busy are ignored.
        set_image(0);
        start_pass(1);
        repeat (10) @(posedge clk);
        #1;
        write_kernel(1, k_neg, 1'b0);
        start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        finish_pass("busy_ignore", 1, 200);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/conv_stream_engine.md
Name: conv_stream_engine

Overview:
Parametrised multi-feature 2D convolution engine, the next generation of the CNN convolution stage. Weight kernels are loaded into an internal feature memory. The engine latches a packed image on start and convolves every valid window with every stored feature at a configurable stride. Results stream out over a valid/ready handshake to the pooling stage, tagged with feature, row and column.

Parameters:
IMAGE_WIDTH, 12, image columns
IMAGE_HEIGHT, 12, image rows
NUM_FEATURES, 2, number of kernels held in feature memory
KERNEL_SIZE, 3, square kernel edge
STRIDE, 1, window step in both axes (>=1)
PIXEL_WIDTH, 2, signed pixel width
WEIGHT_WIDTH, 2, signed weight width

Derived (localparam):
- OUT_W = (IMAGE_WIDTH-KERNEL_SIZE)/STRIDE+1, floor division.
- OUT_H = (IMAGE_HEIGHT-KERNEL_SIZE)/STRIDE+1.
- ACC_WIDTH = PIXEL_WIDTH+WEIGHT_WIDTH+$clog2(KERNEL_SIZE*KERNEL_SIZE).

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
image_input  in  PIXEL_WIDTH*IMAGE_HEIGHT*IMAGE_WIDTH  packed signed image; row 0 col 0 in MSBs, row-major
weights_input  in  WEIGHT_WIDTH*KERNEL_SIZE*KERNEL_SIZE  packed signed kernel; element 0 in MSBs
feature_writeAddr  in  $clog2(NUM_FEATURES)+1  feature memory slot to write
feature_WrEn  in  1  active-high weight write strobe
start  in  1  begin a convolution pass
busy  out  1  pass in progress
done  out  1  one-cycle pulse after the last beat is accepted
out_data  out  ACC_WIDTH  signed convolution result
out_feature  out  $clog2(NUM_FEATURES)+1  feature index of the beat
out_row  out  $clog2(OUT_H)+1  output row of the beat
out_col  out  $clog2(OUT_W)+1  output column of the beat
out_valid  out  1  beat valid
out_ready  in  1  downstream accepts beat

Behaviour:
- Reset: state IDLE.
  - busy, done and out_valid are 0.
  - out_data, out_feature, out_row and out_col are 0.
  - Feature memory is cleared to all-zero weights.
  - Reset has priority over every other input, including mid-pass: the beat is dropped, no done pulse is produced, and the engine returns to IDLE on the next edge.
- Weight write:
  - On an edge with feature_WrEn=1, state IDLE and feature_writeAddr<NUM_FEATURES, weights_input is stored in that slot.
  - Writes while busy or to an out-of-range address are ignored.
- State machine: IDLE, COMPUTE, EMIT, FINISH.
  - IDLE: when start=1, latch image_input into the internal image register, zero the counters (feature, row, col), set busy=1, and go to COMPUTE. Start in any other state is ignored.
  - COMPUTE (1 cycle): dot product of the window at (row*STRIDE, col*STRIDE) with the current feature kernel. Multiplication is signed and full-precision, and the sum is carried in ACC_WIDTH so it never overflows. Register the result and tags, set out_valid=1, and go to EMIT.
  - EMIT: out_data and the tags are held stable while out_valid=1 and out_ready=0.
  - On out_valid and out_ready both high:
    - Advance the counters with col fastest, then row, then feature.
    - If the beat was the last one (feature=NUM_FEATURES-1, row=OUT_H-1, col=OUT_W-1), clear out_valid and go to FINISH.
    - Otherwise clear out_valid and go to COMPUTE.
  - FINISH: done=1 for exactly one cycle, busy=0, then go to IDLE.
- Throughput and latency: one beat per 2 cycles with out_ready held high. The first out_valid rises 2 edges after start is sampled.
- Beat count per pass is exactly NUM_FEATURES*OUT_H*OUT_W. Pixels beyond the last full window at the given stride are never read.
- image_input changes during a pass have no effect; the image latched at start is used throughout.
- Tag widths carry one extra bit so that the value 1 is representable when NUM_FEATURES, OUT_H or OUT_W is 1.

Optional Feature:
CONV_RELU_EN
- Defined: out_data = max(sum, 0), i.e. negative sums are emitted as 0. Beat count and timing are unchanged.
- Undefined: the raw signed sum is emitted.

Decomposition:
- Package cnn_pkg holds:
  - the state enum typedef (IDLE, COMPUTE, EMIT, FINISH);
  - functions computing OUT_W, OUT_H and ACC_WIDTH from the parameters, shared with the pooling and flattening stages.
- One sub-module, window_mac: purely combinational signed K*K dot product (window and kernel in, ACC_WIDTH sum out). The engine registers its output in COMPUTE.

Test Plan:
- Defaults; feature 0 = X kernel {1,-1,1,-1,1,-1,1,-1,1}; feature 1 = all 1; all-ones image; out_ready=1 → 200 beats (2*10*10):
  - feature 0 beats all equal 1; feature 1 beats all equal 9;
  - done pulses once, 1 cycle after beat 200.
- All -1 image with feature 1 all 1 → every feature 1 beat is -9. With CONV_RELU_EN defined → every beat is 0.
- STRIDE=2, defaults otherwise → 50 beats (2*5*5); the last beat is tagged feature=1, row=4, col=4.
- Backpressure:
  - out_ready low for 5 cycles on beat 3 → out_data and tags stable and out_valid high throughout;
  - no beat lost or duplicated (row/col sequence contiguous).
- rst=1 asserted mid-pass at beat 40 → next cycle busy=0 and out_valid=0, no done pulse; a new start then yields the full 200-beat pass.
- feature_WrEn=1 while busy with new weights → ignored: remaining beats use the original weights. Start while busy → ignored: the beat count is still 200.
